// File: rtl/lampFPU_pkg.sv
// Shared lampFPU definitions used by the Goldschmidt square-root iteration unit.
package lampFPU_pkg;

    localparam int LAMP_SQRT_ITER    = 2;
    localparam int LAMP_SQRT_PREC_DW = 8;

    typedef enum logic [2:0] {
        GS_IDLE,
        GS_SEED,
        GS_SQ,
        GS_B,
        GS_R,
        GS_X,
        GS_Y,
        GS_DONE
    } sqrt_gs_state_t;

    // MSB of the W-bit Q2 window inside a 2W-bit Q4 product.
    function automatic int sqrt_gs_trunc_msb(input int w);
        return 2 * w - 3;
    endfunction

endpackage

// File: rtl/sqrt_gs_iter_unit_if.sv
// Operand/result handshake bundle of the Goldschmidt sqrt/rsqrt unit.
interface sqrt_gs_iter_unit_if
    import lampFPU_pkg::*;
#(
    parameter int SIG_W  = 8,
    parameter int PREC_W = LAMP_SQRT_PREC_DW,
    parameter int TAG_W  = 4
);
    localparam int W = SIG_W + PREC_W;

    logic               in_valid_i;
    logic               in_ready_o;
    logic [SIG_W-1:0]   s_i;
    logic               mode_i;
    logic [TAG_W-1:0]   tag_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [W-1:0]       res_o;
    logic               inv_o;
    logic [TAG_W-1:0]   tag_o;

    modport master (
        output in_valid_i, s_i, mode_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o, inv_o, tag_o
    );

    modport slave (
        input  in_valid_i, s_i, mode_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o, inv_o, tag_o
    );

endinterface

// File: rtl/sqrt_gs_mul.sv
// Shared W x W unsigned multiply, Q2 x Q2 -> Q2 with truncation toward zero.
// Purely combinational; the caller registers the result.
module sqrt_gs_mul
    import lampFPU_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);
    localparam int LSB = sqrt_gs_trunc_msb(W) - W + 1;

    logic [2*W-1:0] full;

    assign full = (2*W)'(a) * (2*W)'(b);
    // Integer bits above 2^1 are dropped: operands stay below 2, so they are always zero.
    assign p    = W'(full >> LSB);

endmodule

// File: rtl/sqrt_gs_iter_unit.sv
// Goldschmidt sqrt / rsqrt of a normalised significand; result 1 + 5*ITER cycles after accept.
// Result is held in DONE until out_ready_i; a new operand may be accepted on the same edge.
module sqrt_gs_iter_unit
    import lampFPU_pkg::*;
#(
    parameter int SIG_W  = 8,
    parameter int PREC_W = LAMP_SQRT_PREC_DW,
    parameter int ITER   = LAMP_SQRT_ITER,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    sqrt_gs_iter_unit_if.slave bus
);
    localparam int             W      = SIG_W + PREC_W;
    localparam logic [W-1:0]   THREE  = W'(3) << (W - 2);
    localparam logic [2:0]     I_LAST = 3'(ITER - 1);

    sqrt_gs_state_t     state, state_nxt;
    logic [W-1:0]       s_q, b_q, r_q, t_q, x_q, y_q, res_q;
    logic               mode_q, inv_q;
    logic [TAG_W-1:0]   tag_q;
    logic [2:0]         i_q;
    logic [W-1:0]       mul_a, mul_b, mul_p;
    logic [W-1:0]       s_ext, r_init, r_next;
    logic               accept;

    assign accept = bus.in_valid_i && bus.in_ready_o;
    assign s_ext  = {1'b0, bus.s_i, {(PREC_W-1){1'b0}}};
    assign r_init = (THREE - s_ext) >> 1;
    assign r_next = (THREE - b_q) >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= GS_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            GS_IDLE: if (accept) state_nxt = bus.s_i[SIG_W-1] ? GS_SEED : GS_DONE;
            GS_SEED: state_nxt = GS_SQ;
            GS_SQ:   state_nxt = GS_B;
            GS_B:    state_nxt = GS_R;
            GS_R:    state_nxt = GS_X;
            GS_X:    state_nxt = GS_Y;
            GS_Y:    state_nxt = (i_q == I_LAST) ? GS_DONE : GS_SQ;
            GS_DONE: begin
                if (accept)               state_nxt = bus.s_i[SIG_W-1] ? GS_SEED : GS_DONE;
                else if (bus.out_ready_i) state_nxt = GS_IDLE;
            end
            default: state_nxt = GS_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        case (state)
            GS_IDLE: bus.in_ready_o = 1'b1;
            GS_DONE: begin
                bus.out_valid_o = 1'b1;
                bus.in_ready_o  = bus.out_ready_i;
            end
            default: ;
        endcase
    end

    // Operand select for the single shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            GS_SEED: begin mul_a = s_q; mul_b = y_q; end
            GS_SQ:   begin mul_a = r_q; mul_b = r_q; end
            GS_B:    begin mul_a = b_q; mul_b = t_q; end
            GS_X:    begin mul_a = x_q; mul_b = r_q; end
            GS_Y:    begin mul_a = y_q; mul_b = r_q; end
            default: ;
        endcase
    end

    sqrt_gs_mul #(.W(W)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            t_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            res_q  <= '0;
            mode_q <= 1'b0;
            inv_q  <= 1'b0;
            tag_q  <= '0;
            i_q    <= '0;
        end else begin
            case (state)
                GS_IDLE, GS_DONE: begin
                    if (accept) begin
                        s_q    <= s_ext;
                        b_q    <= s_ext;
                        r_q    <= r_init;
                        y_q    <= r_init;
                        mode_q <= bus.mode_i;
                        tag_q  <= bus.tag_i;
                        i_q    <= '0;
                        if (!bus.s_i[SIG_W-1]) begin
                            res_q <= '0;
                            inv_q <= 1'b1;
                        end
                    end
                end
                GS_SEED: x_q <= mul_p;
                GS_SQ:   t_q <= mul_p;
                GS_B:    b_q <= mul_p;
                GS_R:    r_q <= r_next;
                GS_X:    x_q <= mul_p;
                GS_Y: begin
                    y_q <= mul_p;
                    i_q <= i_q + 3'd1;
                    // The final y is the multiplier output of this very state.
                    if (i_q == I_LAST) begin
                        res_q <= mode_q ? mul_p : x_q;
                        inv_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res_o = res_q;
    assign bus.inv_o = inv_q;
    assign bus.tag_o = tag_q;

endmodule
